note_gate_ctrl: RTL and testbench

Downstream consumer of the autoplay message stream. Captures each (clk_msg, msg) note message into a small FIFO and decodes it. Drives a note code plus a gate signal to the tone generator, including re-articulation gaps, legato changes and automatic release. Runs on the 1 kHz playback clock, so one clock = 1 ms.

---
 rtl/note_gate_ctrl.sv | 257 +++++++++++++++++++++++++
 tb/tb_note_gate_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/note_gate_ctrl.sv
// note_gate_ctrl: captures strobed note messages into a small FIFO and turns
// them into a note code plus a gate for the tone generator. It handles
// re-articulation gaps, legato changes, rests and automatic release.
// Runs on the 1 kHz playback clock (one clock = 1 ms).
// Optional: define NOTE_DIV_EN to drive half_period from a pitch table;
// otherwise half_period is held at zero.
module note_gate_ctrl #(
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned GAP_MS      = 20,
  parameter int unsigned MAX_HOLD_MS = 2000,
  parameter int unsigned CLK_FREQ    = 120_000_000
) (
  input  logic        clk_play,
  input  logic        rst,
  input  logic        clk_msg,
  input  logic [7:0]  msg,
  output logic [7:0]  note,
  output logic        gate,
  output logic        fifo_ovf,
  output logic [7:0]  err_cnt,
  output logic [23:0] half_period
);

  localparam int unsigned     DEPTH     = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_CNT = DEPTH[FIFO_AW:0];
  // A zero gap length behaves as a one-clock gap.
  localparam logic [15:0]     GAP_LAST  = (GAP_MS == 0) ? 16'd0 : 16'(GAP_MS - 1);
  localparam logic [15:0]     HOLD_LAST = 16'(MAX_HOLD_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_GAP
  } state_t;

  // ---------------------------------------------------------------------
  // Message capture and decode
  // ---------------------------------------------------------------------
  logic clk_msg_q;
  logic capture;
  logic msg_rest;
  logic msg_note;
  logic msg_valid;

  // Delay the strobe by one clock so a rising strobe is seen exactly once.
  always_ff @(posedge clk_play or posedge rst) begin
    if (rst) clk_msg_q <= 1'b0;
    else     clk_msg_q <= clk_msg;
  end

  // Rising-strobe detect and message classification.
  always_comb begin
    capture   = clk_msg & ~clk_msg_q;
    msg_rest  = (msg == 8'h00);
    msg_note  = ~msg[7] && (msg[3:0] >= 4'd1) && (msg[3:0] <= 4'd12);
    msg_valid = msg_rest | msg_note;
  end

  // ---------------------------------------------------------------------
  // Message FIFO
  // ---------------------------------------------------------------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;
  logic [FIFO_AW:0]   count_d;
  logic               fifo_empty;
  logic               fifo_full;
  logic               push_req;
  logic               push;
  logic               pop;
  logic [7:0]         head;
  state_t             state_q;

  // The FSM pops whenever it is not gapping and data is waiting; a full FIFO
  // still accepts a push when a pop happens on the same edge.
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == DEPTH_CNT);
    head       = mem_q[rd_ptr_q];
    pop        = (state_q != S_GAP) && !fifo_empty;
    push_req   = capture && msg_valid;
    push       = push_req && (!fifo_full || pop);
    count_d    = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_play) begin
    if (push) mem_q[wr_ptr_q] <= msg;
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk_play or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------
  // Error / overflow status
  // ---------------------------------------------------------------------
  logic       fifo_ovf_q;
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;

  // Saturating count of dropped invalid messages.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (capture && !msg_valid && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Sticky overflow flag and error counter registers.
  always_ff @(posedge clk_play or posedge rst) begin
    if (rst) begin
      fifo_ovf_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (push_req && !push) fifo_ovf_q <= 1'b1;
      err_cnt_q <= err_cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Half-period lookup for the entry at the FIFO head
  // ---------------------------------------------------------------------
  logic [23:0] hp_head;

`ifdef NOTE_DIV_EN
  // Half-period in CLK_FREQ cycles of pitch k in octave 0 (C0 = 16.352 Hz),
  // evaluated only at elaboration to fill the constant table.
  function automatic logic [23:0] base_hp(input int unsigned k);
    real r;
    case (k)
      0:       r = 1.0;
      1:       r = 1.0594630943592953;
      2:       r = 1.1224620483093730;
      3:       r = 1.1892071150027210;
      4:       r = 1.2599210498948732;
      5:       r = 1.3348398541700344;
      6:       r = 1.4142135623730951;
      7:       r = 1.4983070768766815;
      8:       r = 1.5874010519681994;
      9:       r = 1.6817928305074290;
      10:      r = 1.7817974362806785;
      default: r = 1.8877486253633870;
    endcase
    return 24'($rtoi(real'(CLK_FREQ) / (2.0 * 16.352 * r) + 0.5));
  endfunction

  localparam logic [23:0] BASE [12] = '{
    base_hp(0), base_hp(1), base_hp(2),  base_hp(3),
    base_hp(4), base_hp(5), base_hp(6),  base_hp(7),
    base_hp(8), base_hp(9), base_hp(10), base_hp(11)
  };

  logic [3:0] pitch_idx;

  // Table value shifted down by the octave; a rest maps to zero.
  always_comb begin
    pitch_idx = head[3:0] - 4'd1;
    hp_head   = '0;
    if ((head[3:0] >= 4'd1) && (head[3:0] <= 4'd12)) hp_head = BASE[pitch_idx] >> head[6:4];
  end
`else
  // No pitch table in this build.
  always_comb begin
    hp_head = '0;
  end
`endif

  // ---------------------------------------------------------------------
  // Gate FSM
  // ---------------------------------------------------------------------
  logic [7:0]  note_q;
  logic        gate_q;
  logic [23:0] half_period_q;
  logic [15:0] hold_cnt_q;
  logic [15:0] gap_cnt_q;

  // Playback state machine: pops messages, times holds and gaps, drives outputs.
  always_ff @(posedge clk_play or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      note_q        <= '0;
      gate_q        <= 1'b0;
      half_period_q <= '0;
      hold_cnt_q    <= '0;
      gap_cnt_q     <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            if (head == 8'h00) begin
              note_q        <= '0;
              half_period_q <= '0;
            end else begin
              note_q        <= head;
              half_period_q <= hp_head;
              gate_q        <= 1'b1;
              hold_cnt_q    <= '0;
              state_q       <= S_ON;
            end
          end
        end
        S_ON: begin
          // A waiting message wins over the hold timeout on the same edge.
          if (pop) begin
            if (head == 8'h00) begin
              gate_q        <= 1'b0;
              note_q        <= '0;
              half_period_q <= '0;
              state_q       <= S_IDLE;
            end else if (head == note_q) begin
              gate_q    <= 1'b0;
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end else begin
              note_q        <= head;
              half_period_q <= hp_head;
              hold_cnt_q    <= '0;
            end
          end else if (hold_cnt_q == HOLD_LAST) begin
            gate_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            hold_cnt_q <= hold_cnt_q + 16'd1;
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            gate_q     <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= S_ON;
          end else begin
            gap_cnt_q <= gap_cnt_q + 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign note        = note_q;
  assign gate        = gate_q;
  assign fifo_ovf    = fifo_ovf_q;
  assign err_cnt     = err_cnt_q;
  assign half_period = half_period_q;

endmodule

// File: tb/tb_note_gate_ctrl.sv
// Directed bench for note_gate_ctrl with default parameters
// (GAP_MS=20, MAX_HOLD_MS=2000, FIFO depth 4).
module tb_note_gate_ctrl;

`ifdef NOTE_DIV_EN
  localparam logic [31:0] HP41 = 32'd229329;
`else
  localparam logic [31:0] HP41 = 32'd0;
`endif

  logic        clk_play;
  logic        rst;
  logic        clk_msg;
  logic [7:0]  msg;
  logic [7:0]  note;
  logic        gate;
  logic        fifo_ovf;
  logic [7:0]  err_cnt;
  logic [23:0] half_period;

  int unsigned n_pass;
  int unsigned n_total;

  note_gate_ctrl #(
    .FIFO_AW    (2),
    .GAP_MS     (20),
    .MAX_HOLD_MS(2000),
    .CLK_FREQ   (120_000_000)
  ) dut (
    .clk_play   (clk_play),
    .rst        (rst),
    .clk_msg    (clk_msg),
    .msg        (msg),
    .note       (note),
    .gate       (gate),
    .fifo_ovf   (fifo_ovf),
    .err_cnt    (err_cnt),
    .half_period(half_period)
  );

  initial clk_play = 1'b0;
  always #5 clk_play = ~clk_play;

  task automatic tick();
    @(posedge clk_play);
    #1;
  endtask

  // One-clock strobe: capture on the first edge, strobe low before the second.
  task automatic strobe(input logic [7:0] v);
    clk_msg = 1'b1;
    msg     = v;
    tick();
    clk_msg = 1'b0;
    msg     = 8'h00;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    clk_msg = 1'b0;
    msg     = 8'h00;

    // Reset state, before any clock edge.
    #1;
    chk("rst_note", 32'(note), 32'h00);
    chk("rst_gate", 32'(gate), 32'd0);
    chk("rst_ovf", 32'(fifo_ovf), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    chk("rst_hp", 32'(half_period), 32'd0);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single note: one clock latency, then auto-release after 2000 clocks.
    clk_msg = 1'b1;
    msg     = 8'h41;
    tick();
    chk("single_latency_gate", 32'(gate), 32'd0);
    clk_msg = 1'b0;
    msg     = 8'h00;
    tick();
    chk("single_note", 32'(note), 32'h41);
    chk("single_gate", 32'(gate), 32'd1);
    chk("single_hp", 32'(half_period), HP41);
    repeat (1999) tick();
    chk("hold_1999_gate", 32'(gate), 32'd1);
    tick();
    chk("hold_2000_gate", 32'(gate), 32'd0);
    chk("hold_2000_note", 32'(note), 32'h41);
    chk("hold_2000_hp", 32'(half_period), HP41);

    // Invalid messages are dropped and counted; a wide strobe counts once.
    strobe(8'h0D);
    strobe(8'h80);
    strobe(8'h10);
    chk("inv_err3", 32'(err_cnt), 32'd3);
    chk("inv_note", 32'(note), 32'h41);
    chk("inv_gate", 32'(gate), 32'd0);
    clk_msg = 1'b1;
    msg     = 8'hFF;
    repeat (3) tick();
    clk_msg = 1'b0;
    msg     = 8'h00;
    tick();
    chk("inv_wide_err4", 32'(err_cnt), 32'd4);
    chk("inv_wide_gate", 32'(gate), 32'd0);

    // Repeated note: 20-clock gate-low gap.
    strobe(8'h45);
    chk("rep_first_note", 32'(note), 32'h45);
    chk("rep_first_gate", 32'(gate), 32'd1);
    repeat (8) tick();
    strobe(8'h45);
    chk("rep_gap_gate", 32'(gate), 32'd0);
    repeat (19) tick();
    chk("rep_gap19_gate", 32'(gate), 32'd0);
    chk("rep_gap19_note", 32'(note), 32'h45);
    tick();
    chk("rep_gap20_gate", 32'(gate), 32'd1);
    chk("rep_gap20_note", 32'(note), 32'h45);

    // Legato changes keep the gate high; a rest closes it.
    strobe(8'h41);
    chk("leg1_note", 32'(note), 32'h41);
    chk("leg1_gate", 32'(gate), 32'd1);
    repeat (3) tick();
    strobe(8'h43);
    chk("leg2_note", 32'(note), 32'h43);
    chk("leg2_gate", 32'(gate), 32'd1);
    strobe(8'h00);
    chk("rest_note", 32'(note), 32'h00);
    chk("rest_gate", 32'(gate), 32'd0);
    chk("rest_hp", 32'(half_period), 32'd0);

    // Overflow: five pushes during a gap, four stored and played in order.
    strobe(8'h45);
    strobe(8'h45);
    chk("ovf_in_gap", 32'(gate), 32'd0);
    strobe(8'h41);
    strobe(8'h42);
    strobe(8'h43);
    strobe(8'h44);
    chk("ovf_after4", 32'(fifo_ovf), 32'd0);
    strobe(8'h46);
    chk("ovf_after5", 32'(fifo_ovf), 32'd1);
    repeat (9) tick();
    chk("ovf_gap_end_pre", 32'(gate), 32'd0);
    tick();
    chk("ovf_gap_end_gate", 32'(gate), 32'd1);
    chk("ovf_gap_end_note", 32'(note), 32'h45);
    tick();
    chk("ovf_play1", 32'(note), 32'h41);
    tick();
    chk("ovf_play2", 32'(note), 32'h42);
    tick();
    chk("ovf_play3", 32'(note), 32'h43);
    tick();
    chk("ovf_play4", 32'(note), 32'h44);
    tick();
    chk("ovf_dropped", 32'(note), 32'h44);
    chk("ovf_gate", 32'(gate), 32'd1);
    chk("ovf_sticky", 32'(fifo_ovf), 32'd1);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) strobe(8'h8F);
    chk("err_sat", 32'(err_cnt), 32'd255);

    // Reset mid-note drops the gate and clears all outputs at once.
    strobe(8'h41);
    chk("rstmid_note", 32'(note), 32'h41);
    chk("rstmid_gate", 32'(gate), 32'd1);
    chk("rstmid_hp", 32'(half_period), HP41);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_async_gate", 32'(gate), 32'd0);
    chk("rstmid_async_note", 32'(note), 32'h00);
    chk("rstmid_async_hp", 32'(half_period), 32'd0);
    chk("rstmid_async_ovf", 32'(fifo_ovf), 32'd0);
    chk("rstmid_async_err", 32'(err_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Reset flushes queued messages.
    strobe(8'h45);
    strobe(8'h45);
    strobe(8'h43);
    chk("flush_pre_gate", 32'(gate), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    tick();
    chk("flush_gate1", 32'(gate), 32'd0);
    chk("flush_note1", 32'(note), 32'h00);
    repeat (25) tick();
    chk("flush_gate25", 32'(gate), 32'd0);
    chk("flush_note25", 32'(note), 32'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
